// File: rtl/memory_responder_if.sv
// Request/response bundle between the RISC-SPM controller side and the memory responder.
// The err wire exists only when BOUNDS_CHECK_EN is defined.
interface memory_responder_if #(
    parameter int ws = 8
);
    logic [ws-1:0] address;
    logic [ws-1:0] data_in;
    logic          req;
    logic          wr;
    logic [ws-1:0] data_out;
    logic          ack;
    logic          busy;
`ifdef BOUNDS_CHECK_EN
    logic          err;

    modport master (
        output address, data_in, req, wr,
        input  data_out, ack, busy, err
    );

    modport slave (
        input  address, data_in, req, wr,
        output data_out, ack, busy, err
    );
`else
    modport master (
        output address, data_in, req, wr,
        input  data_out, ack, busy
    );

    modport slave (
        input  address, data_in, req, wr,
        output data_out, ack, busy
    );
`endif
endinterface

// File: rtl/memory_responder.sv
// Word-wide RAM responder with WAIT_STATES extra cycles and a req/ack handshake.
// Define BOUNDS_CHECK_EN to flag (and suppress) accesses at addresses >= MEM_DEPTH via err.
module memory_responder #(
    parameter int ws          = 8,
    parameter int MEM_DEPTH   = 256,
    parameter int WAIT_STATES = 2
) (
    input  logic              clk,
    input  logic              rst,
    memory_responder_if.slave bus
);
    localparam int AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [3:0] CNT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t        state;
    logic [3:0]    cnt;
    logic          ack_r;
    logic          busy_r;
    logic [ws-1:0] data_out_r;

    logic [ws-1:0] mem [MEM_DEPTH];

    logic [AW-1:0] addr_p1;
    logic          wr_p1;
    logic [ws-1:0] data_p1;
    logic          oor_p1;

    logic          oor_in;
    logic          accept;
    logic          go_resp;
    logic          cur_wr;
    logic          cur_oor;
    logic [AW-1:0] cur_idx;
    logic          mem_we;

    // Out-of-range reads return zero instead of the aliased word.
    function automatic logic [ws-1:0] read_word(input logic oor, input logic [ws-1:0] word);
        return oor ? '0 : word;
    endfunction

`ifdef BOUNDS_CHECK_EN
    logic err_r;

    generate
        if (AW < ws) begin : g_hi_bits
            assign oor_in = |bus.address[ws-1:AW];
        end else begin : g_no_hi_bits
            assign oor_in = 1'b0;
        end
    endgenerate

    assign bus.err = err_r;
`else
    // Upper address bits are intentionally ignored: addresses wrap modulo MEM_DEPTH.
    logic unused_addr;
    assign unused_addr = ^bus.address;
    assign oor_in      = 1'b0;
`endif

    assign accept  = (state == IDLE) && bus.req;
    assign go_resp = (accept && (WAIT_STATES == 0)) || ((state == WAIT) && (cnt == 4'd0));

    // With zero wait states the response is formed on the accept edge, so the live inputs are used.
    assign cur_wr  = (state == IDLE) ? bus.wr                 : wr_p1;
    assign cur_oor = (state == IDLE) ? oor_in                 : oor_p1;
    assign cur_idx = (state == IDLE) ? bus.address[AW-1:0]    : addr_p1;

    // A reset edge during RESP aborts the transfer, so the write is gated by rst too.
    assign mem_we  = (state == RESP) && wr_p1 && !oor_p1 && !rst;

    // ---- accept stage: latch request copies (data, no reset) ----
    always_ff @(posedge clk) begin
        if (accept) begin
            addr_p1 <= bus.address[AW-1:0];
            wr_p1   <= bus.wr;
            data_p1 <= bus.data_in;
            oor_p1  <= oor_in;
        end
    end

    // ---- response stage: memory commit at the end of RESP ----
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[addr_p1] <= data_p1;
        end
    end

    // ---- control FSM with registered outputs ----
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= 4'd0;
            ack_r      <= 1'b0;
            busy_r     <= 1'b0;
            data_out_r <= '0;
`ifdef BOUNDS_CHECK_EN
            err_r      <= 1'b0;
`endif
        end else begin
            ack_r <= go_resp;
`ifdef BOUNDS_CHECK_EN
            err_r <= go_resp && cur_oor;
`endif
            if (go_resp && !cur_wr) begin
                data_out_r <= read_word(cur_oor, mem[cur_idx]);
            end

            unique case (state)
                IDLE: begin
                    if (bus.req) begin
                        busy_r <= 1'b1;
                        cnt    <= CNT_INIT;
                        state  <= (WAIT_STATES == 0) ? RESP : WAIT;
                    end
                end
                WAIT: begin
                    if (cnt == 4'd0) begin
                        state <= RESP;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RESP: begin
                    busy_r <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    busy_r <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    assign bus.data_out = data_out_r;
    assign bus.ack      = ack_r;
    assign bus.busy     = busy_r;

endmodule

// File: tb/tb_memory_responder.sv
// Directed bench: dut_a (WAIT_STATES=2, MEM_DEPTH=64) and dut_b (WAIT_STATES=0, MEM_DEPTH=256).
// Expectations for out-of-range access follow BOUNDS_CHECK_EN when it is defined.
module tb_memory_responder;
    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    memory_responder_if #(.ws(8)) bus_a ();
    memory_responder_if #(.ws(8)) bus_b ();

    memory_responder #(.ws(8), .MEM_DEPTH(64), .WAIT_STATES(2)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a)
    );

    memory_responder #(.ws(8), .MEM_DEPTH(256), .WAIT_STATES(0)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b)
    );

    int n_chk = 0;
    int n_bad = 0;

    logic       use_b;
    logic       s_ack;
    logic       s_busy;
    logic       s_err;
    logic [7:0] s_dout;

    assign s_ack  = use_b ? bus_b.ack      : bus_a.ack;
    assign s_busy = use_b ? bus_b.busy     : bus_a.busy;
    assign s_dout = use_b ? bus_b.data_out : bus_a.data_out;
`ifdef BOUNDS_CHECK_EN
    assign s_err  = use_b ? bus_b.err      : bus_a.err;
`else
    assign s_err  = 1'b0;
`endif

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic r, input logic w, input logic [7:0] a, input logic [7:0] d);
        if (use_b) begin
            bus_b.req = r; bus_b.wr = w; bus_b.address = a; bus_b.data_in = d;
        end else begin
            bus_a.req = r; bus_a.wr = w; bus_a.address = a; bus_a.data_in = d;
        end
    endtask

    // One access; after the accept edge the inputs are scrambled (address a2, inverted wr, zero data).
    task automatic acc(input logic w, input logic [7:0] a, input logic [7:0] d, input logic [7:0] a2,
                       output logic [7:0] dout, output int lat, output logic e);
        @(negedge clk);
        drive(1'b1, w, a, d);
        @(posedge clk);
        @(negedge clk);
        drive(1'b0, ~w, a2, 8'h00);
        lat = 1;
        while (!s_ack && lat < 20) begin
            chk("busy_wait", s_busy, 1);
            @(negedge clk);
            lat++;
        end
        chk("busy_at_ack", s_busy, 1);
        dout = s_dout;
        e    = s_err;
        @(negedge clk);
        chk("ack_one_cycle", s_ack, 0);
        chk("busy_cleared", s_busy, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] dout;
        int         lat;
        logic       e;
        int         nack;
        int         ack_at;
        int         ack_cyc [3];

        rst = 1'b1;
        use_b = 1'b1; drive(1'b0, 1'b0, 8'h00, 8'h00);
        use_b = 1'b0; drive(1'b0, 1'b0, 8'h00, 8'h00);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        chk("rst_ack_a",  bus_a.ack, 0);
        chk("rst_busy_a", bus_a.busy, 0);
        chk("rst_dout_a", bus_a.data_out, 8'h00);
        chk("rst_ack_b",  bus_b.ack, 0);
        chk("rst_dout_b", bus_b.data_out, 8'h00);
        chk("rst_err_a",  s_err, 0);

        // Seed 0x10, read it back so data_out is nonzero before the abort.
        acc(1'b1, 8'h10, 8'h11, 8'h00, dout, lat, e);
        chk("wr10_lat", lat, 3);
        acc(1'b0, 8'h10, 8'h00, 8'h00, dout, lat, e);
        chk("rd10_pre", dout, 8'h11);

        // Abort a write of 0xAA to 0x10 with two reset cycles during WAIT.
        @(negedge clk);
        drive(1'b1, 1'b1, 8'h10, 8'hAA);
        @(posedge clk);
        @(negedge clk);
        drive(1'b0, 1'b0, 8'h00, 8'h00);
        chk("abort_busy_wait", s_busy, 1);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_ack_in_rst", s_ack, 0);
        @(negedge clk);
        rst = 1'b0;
        chk("abort_ack", s_ack, 0);
        chk("abort_busy", s_busy, 0);
        chk("abort_dout", s_dout, 8'h00);
        nack = 0;
        repeat (4) begin
            @(negedge clk);
            if (s_ack) nack++;
        end
        chk("abort_no_late_ack", nack, 0);
        acc(1'b0, 8'h10, 8'h00, 8'h00, dout, lat, e);
        chk("abort_mem_kept", dout, 8'h11);

        // Write 0x3C to 0x05: three-cycle latency, data_out untouched by a write.
        acc(1'b1, 8'h05, 8'h3C, 8'h00, dout, lat, e);
        chk("wr05_lat", lat, 3);
        chk("wr05_dout_hold", dout, 8'h11);
        acc(1'b0, 8'h05, 8'h00, 8'h00, dout, lat, e);
        chk("rd05_lat", lat, 3);
        chk("rd05_data", dout, 8'h3C);

        // Request pulsed during WAIT is ignored.
        acc(1'b1, 8'h20, 8'h99, 8'h00, dout, lat, e);
        @(negedge clk);
        drive(1'b1, 1'b0, 8'h05, 8'h00);
        @(posedge clk);
        nack = 0;
        ack_at = 0;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (s_ack) begin
                nack++;
                ack_at = i;
                chk("busyreq_dout", s_dout, 8'h3C);
            end
            if (i == 1) drive(1'b1, 1'b0, 8'h20, 8'h00);
            else if (i == 2) drive(1'b0, 1'b0, 8'h20, 8'h00);
        end
        chk("busyreq_nack", nack, 1);
        chk("busyreq_ack_cycle", ack_at, 3);
        chk("busyreq_dout_after", s_dout, 8'h3C);

        // Address changes to 0x7F right after a read of 0x01 is accepted.
        acc(1'b1, 8'h3F, 8'hC3, 8'h00, dout, lat, e);
        acc(1'b1, 8'h01, 8'h66, 8'h00, dout, lat, e);
        acc(1'b0, 8'h01, 8'h00, 8'h7F, dout, lat, e);
        chk("latched_addr", dout, 8'h66);

        // 0x41 is beyond the 64-word array.
        acc(1'b1, 8'h41, 8'h55, 8'h00, dout, lat, e);
        chk("oor_wr_lat", lat, 3);
`ifdef BOUNDS_CHECK_EN
        chk("oor_wr_err", e, 1);
        acc(1'b0, 8'h41, 8'h00, 8'h00, dout, lat, e);
        chk("oor_rd_err", e, 1);
        chk("oor_rd_data", dout, 8'h00);
        acc(1'b0, 8'h01, 8'h00, 8'h00, dout, lat, e);
        chk("oor_mem01_kept", dout, 8'h66);
        chk("inrange_err", e, 0);
        chk("err_idle", s_err, 0);
`else
        acc(1'b0, 8'h41, 8'h00, 8'h00, dout, lat, e);
        chk("wrap_rd41", dout, 8'h55);
        acc(1'b0, 8'h01, 8'h00, 8'h00, dout, lat, e);
        chk("wrap_rd01", dout, 8'h55);
`endif

        // Zero-wait-state responder.
        use_b = 1'b1;
        acc(1'b1, 8'h00, 8'h12, 8'h00, dout, lat, e);
        chk("b_wr_lat", lat, 1);
        acc(1'b0, 8'h00, 8'h00, 8'h00, dout, lat, e);
        chk("b_rd_lat", lat, 1);
        chk("b_rd_data", dout, 8'h12);
        acc(1'b1, 8'hFF, 8'hE7, 8'h00, dout, lat, e);
        acc(1'b0, 8'hFF, 8'h00, 8'h00, dout, lat, e);
        chk("b_rd_top", dout, 8'hE7);
        chk("b_top_err", e, 0);

        // req held high: acks every other cycle.
        @(negedge clk);
        drive(1'b1, 1'b0, 8'h00, 8'h00);
        @(posedge clk);
        nack = 0;
        for (int i = 0; i < 3; i++) ack_cyc[i] = 0;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (s_ack) begin
                ack_cyc[nack] = i;
                nack++;
                chk("b_held_data", s_dout, 8'h12);
                if (nack == 3) begin
                    drive(1'b0, 1'b0, 8'h00, 8'h00);
                    break;
                end
            end
        end
        chk("b_held_nack", nack, 3);
        chk("b_held_ack1", ack_cyc[0], 1);
        chk("b_held_ack2", ack_cyc[1], 3);
        chk("b_held_ack3", ack_cyc[2], 5);
        @(negedge clk);
        chk("b_held_idle_ack", s_ack, 0);
        chk("b_held_idle_busy", s_busy, 0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule

// File: doc/memory_responder.md
Name: memory_responder

Overview:
- Memory-side responder that consumes the address driven by the address register and services one read or write per request.
- Sits between the address register / Bus_1 and the RISC-SPM control unit.
- Models a word-wide RAM with a configurable number of wait states and a req/ack handshake, so the controller can be exercised against slow memory.
- Read data returns on data_out, which feeds Bus_2 via the datapath mux.

Parameters:
- ws, 8, word size in bits; applies to address and data.
- MEM_DEPTH, 256, number of words. Must be a power of two and no greater than 2^ws. AW = log2(MEM_DEPTH).
- WAIT_STATES, 2, extra cycles between request acceptance and response, 0..15.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- rst  input  1  synchronous, active-high reset.
- address  input  ws  word address from the address register output.
- data_in  input  ws  write data from Bus_1.
- req  input  1  request strobe; sampled only in IDLE.
- wr  input  1  1 = write, 0 = read; sampled together with req.
- data_out  output  ws  read data, registered.
- ack  output  1  one-cycle completion pulse.
- busy  output  1  request in progress.
- err  output  1  out-of-range flag; exists only when BOUNDS_CHECK_EN is defined.

Behaviour:
- Reset (rst high at a clock edge):
  - state = IDLE; ack, busy, err and data_out = 0; wait counter = 0.
  - Memory array contents are not cleared.
- States: IDLE, WAIT, RESP.
- IDLE:
  - If req = 1, latch address, wr and data_in into internal registers and set busy = 1.
  - Next state is WAIT if WAIT_STATES > 0, otherwise RESP.
  - Load the counter with WAIT_STATES-1.
- WAIT: busy = 1. Decrement the counter; when it reaches 0, go to RESP next cycle. The state lasts exactly WAIT_STATES cycles.
- RESP:
  - ack = 1 for exactly this cycle; busy remains 1.
  - Write: mem[latched_addr] <= latched_data; data_out is unchanged.
  - Read: data_out <= mem[latched_addr], and is visible in the same cycle as ack (ack and data_out are updated on the same edge).
  - Next state is IDLE.
- Latency: req sampled at edge n gives ack high during cycle n+1+WAIT_STATES.
- data_out holds the last read value until the next read completes or reset.
- req while busy: ignored, no queueing. No acceptance occurs in the RESP cycle, so req held high gives back-to-back accesses separated by one IDLE cycle.
- Address, wr and data_in may change after the accept edge; only the latched copies are used.
- Address indexing: only the low AW bits index the array. Upper bits are handled as described under Optional Feature.
- Read-after-write to the same address in the next request returns the newly written value.
- Reset mid-operation (in WAIT or RESP before the edge): the request is aborted and a pending write is not committed. ack is never issued for it.
- rst and req high together: reset wins; the request is not accepted.

Optional Feature:
- Macro: BOUNDS_CHECK_EN.
- Defined: a latched address >= MEM_DEPTH completes with normal timing, but:
  - err = 1 in the RESP cycle, alongside ack;
  - writes are dropped;
  - reads return data_out = 0.
  - err is 0 in all other cycles.
- Not defined: no err port; addresses wrap modulo MEM_DEPTH (upper bits ignored).

Test Plan:
- Reset: hold rst 2 cycles mid-WAIT of a write to 0x10 with data 0xAA, then read 0x10 -> ack, busy, data_out = 0 after reset; mem[0x10] is unchanged (not 0xAA).
- WAIT_STATES=2: write 0x3C to 0x05 at edge n -> ack exactly in cycle n+3, busy during n+1..n+3. Then read 0x05 -> data_out = 0x3C with ack.
- WAIT_STATES=0: read 0x00 -> ack in cycle n+1. Hold req high for 3 accesses -> acks spaced 2 cycles apart.
- Request while busy: pulse req (read 0x20) during WAIT -> no extra ack. The first transaction completes normally and data_out is not disturbed.
- Input change after accept: change address to 0x7F the cycle after accepting a read of 0x01 -> data_out = mem[0x01].
- BOUNDS_CHECK_EN, MEM_DEPTH=64: write 0x55 to 0x41, then read 0x41 -> err = 1 with each ack, read returns 0x00, mem[0x01] unchanged. Without the macro, the same read returns 0x55 (wrap to 0x01).
